// File: rtl/mem_arbiter.sv
// Round-robin, lockable arbiter sharing one single-port memory between the host
// command path and the gpu sprite engine; every access costs an IDLE->ISSUE pair.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  h_req,
  input  logic                  g_req,
  input  logic                  h_lock,
  input  logic                  g_lock,
  input  logic                  h_write,
  input  logic                  g_write,
  input  logic [ADDR_WIDTH-1:0] h_addr,
  input  logic [ADDR_WIDTH-1:0] g_addr,
  input  logic [DATA_WIDTH-1:0] h_wdata,
  input  logic [DATA_WIDTH-1:0] g_wdata,
  output logic                  h_ack,
  output logic                  g_ack,
  output logic                  h_rvalid,
  output logic                  g_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_byte,
  input  logic [DATA_WIDTH-1:0] mem_read_byte,
  output logic                  dbg_state
);

  // Handshake: a requester raises req with stable fields and holds them until
  // its one-cycle ack; read data arrives on rdata with a one-cycle rvalid the
  // cycle after the ack. Req is not looked at while an access is in ISSUE.
  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;
  typedef enum logic {OWN_HOST = 1'b0, OWN_GPU = 1'b1} owner_t;

  state_t                state_q, state_d;
  owner_t                owner_q, owner_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wbyte_q, mem_wbyte_d;
  logic                  h_ack_q, h_ack_d;
  logic                  g_ack_q, g_ack_d;
  logic                  h_rvalid_q, h_rvalid_d;
  logic                  g_rvalid_q, g_rvalid_d;

  logic lock_held;
  logic h_elig;
  logic g_elig;
  logic grant_gpu;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wbyte_d = mem_wbyte_q;
    h_ack_d     = 1'b0;
    g_ack_d     = 1'b0;
    h_rvalid_d  = 1'b0;
    g_rvalid_d  = 1'b0;

    // A held lock by the current owner shuts the other side out, even if the
    // owner itself is not requesting right now.
    lock_held = (owner_q == OWN_GPU) ? g_lock : h_lock;
    h_elig    = h_req && (!lock_held || owner_q == OWN_HOST);
    g_elig    = g_req && (!lock_held || owner_q == OWN_GPU);
    grant_gpu = g_elig && (!h_elig || owner_q == OWN_HOST);

    case (state_q)
      IDLE: begin
        if (h_elig || g_elig) begin
          state_d = ISSUE;
          if (grant_gpu) begin
            owner_d     = OWN_GPU;
            mem_read_d  = !g_write;
            mem_write_d = g_write;
            mem_addr_d  = g_addr;
            mem_wbyte_d = g_wdata;
            g_ack_d     = 1'b1;
          end else begin
            owner_d     = OWN_HOST;
            mem_read_d  = !h_write;
            mem_write_d = h_write;
            mem_addr_d  = h_addr;
            mem_wbyte_d = h_wdata;
            h_ack_d     = 1'b1;
          end
        end
      end
      ISSUE: begin
        state_d    = IDLE;
        h_rvalid_d = h_ack_q && mem_read_q;
        g_rvalid_d = g_ack_q && mem_read_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_GPU;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wbyte_q <= '0;
      h_ack_q     <= 1'b0;
      g_ack_q     <= 1'b0;
      h_rvalid_q  <= 1'b0;
      g_rvalid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wbyte_q <= mem_wbyte_d;
      h_ack_q     <= h_ack_d;
      g_ack_q     <= g_ack_d;
      h_rvalid_q  <= h_rvalid_d;
      g_rvalid_q  <= g_rvalid_d;
    end
  end

  assign h_ack          = h_ack_q;
  assign g_ack          = g_ack_q;
  assign h_rvalid       = h_rvalid_q;
  assign g_rvalid       = g_rvalid_q;
  assign rdata          = mem_read_byte;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_byte = mem_wbyte_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a long random run, all checked
// every cycle against a transaction-level model of grants, memory and read returns.
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          h_req = 0, g_req = 0, h_lock = 0, g_lock = 0;
  logic          h_write = 0, g_write = 0;
  logic [AW-1:0] h_addr = '0, g_addr = '0;
  logic [DW-1:0] h_wdata = '0, g_wdata = '0;
  logic          h_ack, g_ack, h_rvalid, g_rvalid;
  logic [DW-1:0] rdata;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_write_byte;
  logic [DW-1:0] mem_read_byte;
  logic          dbg_state;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .h_req(h_req), .g_req(g_req), .h_lock(h_lock), .g_lock(g_lock),
    .h_write(h_write), .g_write(g_write), .h_addr(h_addr), .g_addr(g_addr),
    .h_wdata(h_wdata), .g_wdata(g_wdata),
    .h_ack(h_ack), .g_ack(g_ack), .h_rvalid(h_rvalid), .g_rvalid(g_rvalid),
    .rdata(rdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_write_byte(mem_write_byte),
    .mem_read_byte(mem_read_byte), .dbg_state(dbg_state)
  );

  // Memory: write lands at the edge, read data appears the cycle after mem_read.
  logic [DW-1:0] mem_arr [0:65535] = '{default: 8'h00};
  always @(posedge clk) begin
    if (mem_write) mem_arr[mem_addr] <= mem_write_byte;
    if (mem_read) mem_read_byte <= mem_arr[mem_addr];
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: one access per two cycles, owner-based round robin and lock.
  logic [DW-1:0] shadow [0:65535] = '{default: 8'h00};
  logic [DW-1:0] exp_h_q[$];
  logic [DW-1:0] exp_g_q[$];
  int            cyc = 0;
  int            last_grant_cyc = -100;
  bit            m_owner_gpu = 1'b1;
  logic          exp_mem_read = 0, exp_mem_write = 0, exp_h_ack = 0, exp_g_ack = 0;
  logic          exp_h_rvalid = 0, exp_g_rvalid = 0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wbyte = '0;

  task automatic model_reset();
    exp_mem_read = 0; exp_mem_write = 0; exp_h_ack = 0; exp_g_ack = 0;
    exp_h_rvalid = 0; exp_g_rvalid = 0; exp_addr = '0; exp_wbyte = '0;
    m_owner_gpu = 1'b1;
    last_grant_cyc = cyc - 100;
    exp_h_q.delete();
    exp_g_q.delete();
  endtask

  task automatic model_issue(input bit to_gpu, input logic wr, input logic [AW-1:0] a,
                             input logic [DW-1:0] d);
    last_grant_cyc = cyc;
    m_owner_gpu    = to_gpu;
    exp_addr       = a;
    exp_wbyte      = d;
    exp_mem_write  = wr;
    exp_mem_read   = !wr;
    exp_h_ack      = !to_gpu;
    exp_g_ack      = to_gpu;
    if (wr) shadow[a] = d;
    else if (to_gpu) exp_g_q.push_back(shadow[a]);
    else exp_h_q.push_back(shadow[a]);
  endtask

  // Predicts the cycle that follows the next rising edge from the current inputs.
  task automatic predict();
    bit locked, host_can, gpu_can;
    cyc++;
    exp_h_rvalid = exp_h_ack && exp_mem_read;
    exp_g_rvalid = exp_g_ack && exp_mem_read;
    exp_mem_read = 0; exp_mem_write = 0; exp_h_ack = 0; exp_g_ack = 0;
    if (cyc - last_grant_cyc >= 2) begin
      locked   = m_owner_gpu ? g_lock : h_lock;
      host_can = h_req && !(locked && m_owner_gpu);
      gpu_can  = g_req && !(locked && !m_owner_gpu);
      if (host_can && gpu_can) begin
        if (m_owner_gpu) model_issue(1'b0, h_write, h_addr, h_wdata);
        else model_issue(1'b1, g_write, g_addr, g_wdata);
      end else if (host_can) model_issue(1'b0, h_write, h_addr, h_wdata);
      else if (gpu_can) model_issue(1'b1, g_write, g_addr, g_wdata);
    end
  endtask

  task automatic check_outputs();
    check_eq("mem_read", mem_read, exp_mem_read);
    check_eq("mem_write", mem_write, exp_mem_write);
    check_eq("one_strobe", mem_read & mem_write, 0);
    check_eq("h_ack", h_ack, exp_h_ack);
    check_eq("g_ack", g_ack, exp_g_ack);
    check_eq("h_rvalid", h_rvalid, exp_h_rvalid);
    check_eq("g_rvalid", g_rvalid, exp_g_rvalid);
    check_eq("mem_addr", mem_addr, exp_addr);
    check_eq("mem_write_byte", mem_write_byte, exp_wbyte);
    check_eq("state", dbg_state, exp_h_ack | exp_g_ack);
    if (exp_h_rvalid && exp_h_q.size() > 0) check_eq("h_rdata", rdata, exp_h_q.pop_front());
    if (exp_g_rvalid && exp_g_q.size() > 0) check_eq("g_rdata", rdata, exp_g_q.pop_front());
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge with inputs already set for the coming rising edge.
  task automatic tick();
    predict();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic reset_now();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
  endtask

  task automatic drive_random();
    if (h_req && !exp_h_ack) begin
      if ($urandom_range(0, 19) == 0) h_req = 1'b0;
    end else begin
      h_req   = ($urandom_range(0, 2) != 0);
      h_write = $urandom_range(0, 1);
      h_addr  = AW'($urandom_range(0, 31));
      h_wdata = DW'($urandom_range(0, 255));
    end
    if (g_req && !exp_g_ack) begin
      if ($urandom_range(0, 19) == 0) g_req = 1'b0;
    end else begin
      g_req   = ($urandom_range(0, 2) != 0);
      g_write = $urandom_range(0, 1);
      g_addr  = AW'($urandom_range(0, 31));
      g_wdata = DW'($urandom_range(0, 255));
    end
    if ($urandom_range(0, 7) == 0) g_lock = ~g_lock;
    if ($urandom_range(0, 15) == 0) h_lock = ~h_lock;
  endtask

  // ---------------- test sequence ----------------
  logic [7:0] h_pat;
  logic [7:0] g_pat;
  int         h_cnt, g_cnt, waited;
  bit         got;

  initial begin
    #2;
    reset_now();

    // Host write then read-back of the same byte.
    h_req = 1; h_write = 1; h_addr = 16'h0123; h_wdata = 8'hA5;
    tick();
    check_eq("wr_strobe", mem_write, 1);
    check_eq("wr_addr", mem_addr, 16'h0123);
    check_eq("wr_data", mem_write_byte, 8'hA5);
    check_eq("wr_ack", h_ack, 1);
    h_write = 0;
    tick();
    tick();
    check_eq("rd_ack", h_ack, 1);
    h_req = 0;
    tick();
    check_eq("rd_rvalid", h_rvalid, 1);
    check_eq("rd_data", rdata, 8'hA5);
    check_eq("rd_g_rvalid", g_rvalid, 0);
    tick();

    // Both requesting from reset: host, gpu, host, gpu, each 2 cycles apart.
    reset_now();
    h_req = 1; h_write = 0; h_addr = 16'h0010;
    g_req = 1; g_write = 0; g_addr = 16'h0020;
    h_pat = '0; g_pat = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      h_pat[i] = h_ack;
      g_pat[i] = g_ack;
    end
    check_eq("alt_host", h_pat, 8'b0001_0001);
    check_eq("alt_gpu", g_pat, 8'b0100_0100);
    h_req = 0; g_req = 0;
    tick(); tick();

    // Locked gpu burst of 5 reads while host waits; host wins once lock falls.
    g_lock = 1; g_req = 1; g_write = 0; g_addr = 16'h0100;
    h_req = 1; h_write = 0; h_addr = 16'h0040;
    h_cnt = 0; g_cnt = 0; waited = 0;
    while (g_cnt < 5 && waited < 40) begin
      tick();
      waited++;
      if (h_ack) h_cnt++;
      if (g_ack) begin
        g_cnt++;
        g_addr = g_addr + 1;
        if (g_cnt == 5) begin g_lock = 0; g_req = 0; end
      end
    end
    check_eq("burst_g_acks", g_cnt, 5);
    check_eq("burst_h_acks", h_cnt, 0);
    got = 0;
    for (int i = 0; i < 4 && !got; i++) begin
      tick();
      if (h_ack) got = 1;
    end
    check_eq("after_burst_host", got, 1);
    h_req = 0;
    tick(); tick();

    // Locked owner with no request still blocks the host.
    g_lock = 1; g_req = 1; g_write = 1; g_addr = 16'h0200; g_wdata = 8'h3C;
    got = 0;
    for (int i = 0; i < 6 && !got; i++) begin
      tick();
      if (g_ack) got = 1;
    end
    check_eq("lock_setup", got, 1);
    g_req = 0; h_req = 1; h_write = 0; h_addr = 16'h0200;
    h_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (h_ack) h_cnt++;
    end
    check_eq("lock_blocks_host", h_cnt, 0);
    g_lock = 0;
    got = 0;
    for (int i = 0; i < 2 && !got; i++) begin
      tick();
      if (h_ack) got = 1;
    end
    check_eq("unlock_host_ack", got, 1);
    h_req = 0;
    tick(); tick(); tick();

    // Reset during ISSUE of a host read: no rvalid, then host wins the first tie.
    h_req = 1; h_write = 0; h_addr = 16'h0200;
    tick();
    check_eq("pre_reset_ack", h_ack, 1);
    h_req = 0;
    reset_now();
    check_eq("post_reset_rvalid", h_rvalid, 0);
    h_req = 1; g_req = 1; g_write = 0; g_addr = 16'h0123;
    tick();
    check_eq("post_reset_host_first", h_ack, 1);
    h_req = 0; g_req = 0;
    tick(); tick(); tick(); tick();

    // Long random run against the model.
    for (int i = 0; i < 10000; i++) begin
      drive_random();
      tick();
    end
    h_req = 0; g_req = 0; h_lock = 0; g_lock = 0;
    tick(); tick(); tick(); tick();
    check_eq("h_queue_drained", exp_h_q.size(), 0);
    check_eq("g_queue_drained", exp_g_q.size(), 0);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
